// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with bounded hold time
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       grant_new
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       new_q, new_d;
  logic [7:0] grant_q, grant_d;

  logic [7:0] owner_oh;
  logic [7:0] others;
  logic [7:0] cand;
  logic       take;
  logic [2:0] winner;

  // First set bit of cand, scanning upward from start and wrapping 7->0.
  function automatic logic [2:0] find_first(input logic [7:0] c, input logic [2:0] start);
    logic [2:0] w;
    logic [2:0] k;
    logic       hit;
    w   = start;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = start + 3'(i);
      if (!hit && c[k]) begin
        w   = k;
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  assign owner_oh = 8'b0000_0001 << idx_q;
  assign others   = req & ~owner_oh;

  // State register: all arbitration state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
      hold_q  <= 4'd0;
      new_q   <= 1'b0;
      grant_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      new_q   <= new_d;
      grant_q <= grant_d;
    end
  end

  // Next-state: decide whether to keep the owner, rotate, or go idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    new_d   = 1'b0;
    take    = 1'b0;
    cand    = req;
    winner  = 3'd0;
    case (state_q)
      IDLE: begin
        if (|req) take = 1'b1;
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // Owner released; hand straight to the next requester if any.
          if (|req) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            hold_d  = 4'd0;
          end
        end else if (hold_q < HOLD_LIMIT) begin
          hold_d = hold_q + 4'd1;
        end else if (|others) begin
          // Hold budget spent and someone else waits: force rotation.
          take = 1'b1;
          cand = others;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take) begin
      winner  = find_first(cand, ptr_q);
      state_d = GRANT;
      idx_d   = winner;
      ptr_d   = winner + 3'd1;
      hold_d  = 4'd1;
      new_d   = 1'b1;
    end
  end

  // Output decode: one-hot grant registered alongside the owner index.
  always_comb begin
    grant_d = 8'h00;
    if (state_d == GRANT) grant_d = 8'b0000_0001 << idx_d;
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == GRANT);
  assign grant_new   = new_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       grant_new;

  int checks;
  int errors;

  // Reference model state (arbitration expressed as plain integers)
  int m_valid;
  int m_idx;
  int m_ptr;
  int m_hold;
  int m_new;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .grant_new  (grant_new)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] c, input int p);
    for (int k = 0; k < 8; k++) begin
      if (c[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_new   = 0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    logic [7:0] oth;
    int w;
    w     = -1;
    m_new = 0;
    if (m_valid == 0) begin
      if (r != 8'h00) w = pick(r, m_ptr);
    end else if (!r[m_idx]) begin
      if (r != 8'h00) w = pick(r, m_ptr);
      else begin
        m_valid = 0;
        m_hold  = 0;
      end
    end else if (m_hold < MAX_HOLD) begin
      m_hold = m_hold + 1;
    end else begin
      oth = r;
      oth[m_idx] = 1'b0;
      if (oth != 8'h00) w = pick(oth, m_ptr);
    end
    if (w >= 0) begin
      m_valid = 1;
      m_idx   = w;
      m_ptr   = (w + 1) % 8;
      m_hold  = 1;
      m_new   = 1;
    end
  endtask

  // Advance one clock edge, update the model with the sampled req, settle.
  task automatic step();
    @(posedge clk);
    model_edge(req);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    req = 8'h00;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant cyc %0d: got %h expected 00", i, grant); end
      checks++;
      if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d: got %b expected 0", i, grant_valid); end
      checks++;
      if (grant_new !== 1'b0) begin errors++; $display("FAIL reset_new cyc %0d: got %b expected 0", i, grant_new); end
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_two_req();
    logic [7:0] exp_g [0:8];
    exp_g = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 8'h04, 8'h04, 8'h04, 8'h01};
    do_reset();
    req = 8'b0000_0101;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (grant !== exp_g[i]) begin errors++; $display("FAIL two_req_grant cyc %0d: got %h expected %h", i, grant, exp_g[i]); end
      checks++;
      if (grant_new !== ((i % 4) == 0)) begin errors++; $display("FAIL two_req_new cyc %0d: got %b expected %b", i, grant_new, ((i % 4) == 0)); end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h80;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (grant !== 8'h80 || grant_idx !== 3'd7) begin errors++; $display("FAIL single_grant cyc %0d: got %h/%0d expected 80/7", i, grant, grant_idx); end
      checks++;
      if (grant_new !== (i == 0)) begin errors++; $display("FAIL single_new cyc %0d: got %b expected %b", i, grant_new, (i == 0)); end
    end
  endtask

  task automatic test_back_to_back();
    int cnt [8];
    int e;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    do_reset();
    req = 8'hFF;
    for (int s = 0; s < 9; s++) begin
      step();
      e = s % 8;
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'(e)) begin errors++; $display("FAIL b2b_idx step %0d: got v=%b idx=%0d expected v=1 idx=%0d", s, grant_valid, grant_idx, e); end
      checks++;
      if (grant_new !== 1'b1) begin errors++; $display("FAIL b2b_new step %0d: got %b expected 1", s, grant_new); end
      for (int i = 0; i < 8; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) req[i] = 1'b1;
        end
      end
      req[e] = 1'b0;
      cnt[e] = 2;
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 8'h03;
    step();
    step();
    checks++;
    if (grant !== 8'h01 || grant_new !== 1'b0) begin errors++; $display("FAIL release_hold: got %h/%b expected 01/0", grant, grant_new); end
    req = 8'h02;
    step();
    checks++;
    if (grant !== 8'h02 || grant_valid !== 1'b1) begin errors++; $display("FAIL release_grant: got %h/%b expected 02/1", grant, grant_valid); end
    checks++;
    if (grant_new !== 1'b1) begin errors++; $display("FAIL release_new: got %b expected 1", grant_new); end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    req = 8'h20;
    step();
    checks++;
    if (grant !== 8'h20) begin errors++; $display("FAIL midrst_pre: got %h expected 20", grant); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_new !== 1'b0 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL midrst_async: got %h/%b/%b/%0d expected 00/0/0/0", grant, grant_valid, grant_new, grant_idx);
    end
    req = 8'h30;
    #1;
    rst = 1'b0;
    model_reset();
    step();
    checks++;
    if (grant !== 8'h10 || grant_idx !== 3'd4 || grant_new !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after: got %h/%0d/%b expected 10/4/1", grant, grant_idx, grant_new);
    end
  endtask

  task automatic test_random();
    int wait_c [8];
    int max_wait;
    logic [7:0] exp_g;
    for (int i = 0; i < 8; i++) wait_c[i] = 0;
    max_wait = 0;
    do_reset();
    req = 8'($urandom);
    for (int c = 0; c < 600; c++) begin
      step();
      exp_g = (m_valid != 0) ? (8'h01 << m_idx) : 8'h00;
      checks++;
      if (grant_valid !== (m_valid != 0) || grant !== exp_g) begin
        errors++;
        $display("FAIL rand_grant cyc %0d req %h: got %h/%b expected %h/%b", c, req, grant, grant_valid, exp_g, (m_valid != 0));
      end
      if (m_valid != 0) begin
        checks++;
        if (grant_idx !== 3'(m_idx)) begin errors++; $display("FAIL rand_idx cyc %0d: got %0d expected %0d", c, grant_idx, m_idx); end
      end
      checks++;
      if (grant_new !== (m_new != 0)) begin errors++; $display("FAIL rand_new cyc %0d: got %b expected %b", c, grant_new, (m_new != 0)); end
      for (int i = 0; i < 8; i++) begin
        if (grant_valid && grant_idx == 3'(i)) wait_c[i] = 0;
        else if (req[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      if ($urandom_range(0, 39) == 0) req = 8'h00;
      else begin
        for (int i = 0; i < 8; i++) begin
          if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        end
      end
    end
    checks++;
    if (max_wait > 7 * MAX_HOLD + 1) begin errors++; $display("FAIL rand_starvation: got wait %0d expected <= %0d", max_wait, 7 * MAX_HOLD + 1); end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    req    = 8'h00;
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_two_req();
    test_single();
    test_back_to_back();
    test_release();
    test_reset_midgrant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
